// File: rtl/sgd_serial_loader.sv
// rtl/sgd_serial_loader.sv - serial sample loader that assembles words and emits indexed write strobes
module sgd_serial_loader #(
   parameter int WORD_W    = 16,
   parameter int LANES     = 1,
   parameter int FEAT_W    = 4,
   parameter int PTS_W     = 12,
   parameter int MSB_FIRST = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [LANES-1:0]  S,
   input  logic              START,
   input  logic              ABORT,
   input  logic [FEAT_W-1:0] feat,
   input  logic [PTS_W-1:0]  data_points,
   output logic              WR_EN,
   output logic [PTS_W-1:0]  WR_PT,
   output logic [FEAT_W-1:0] WR_COL,
   output logic [WORD_W-1:0] WR_DATA,
   output logic              BUSY,
   output logic              LOAD_DONE,
   output logic              ERR
);

   localparam int N    = WORD_W / LANES;
   localparam int SC_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [FEAT_W-1:0] feat_r;
   logic [FEAT_W-1:0] col;
   logic [PTS_W-1:0]  pts_r;
   logic [PTS_W-1:0]  pt;
   logic [SC_W-1:0]   slice;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] word_nxt;
   logic              accept;
   logic              last_slice;
   logic              last_col;
   logic              last_word;

   assign last_slice = (slice == SC_W'(N - 1));
   assign last_col   = (col == '0);
   assign last_word  = last_slice && last_col && (pt == pts_r - PTS_W'(1));

   // Merge the incoming slice into the partial word; the shift direction sets the bit order
   generate
      if (MSB_FIRST != 0) begin : g_msb
         always_comb begin
            word_nxt = WORD_W'({shreg, S});
         end
      end else begin : g_lsb
         always_comb begin
            word_nxt = WORD_W'({S, shreg} >> LANES);
         end
      end
   endgenerate

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic, START acceptance and BUSY; ABORT wins over START
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      BUSY      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (START && !ABORT) begin
               accept    = 1'b1;
               state_nxt = (data_points != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            BUSY = 1'b1;
            if (ABORT)          state_nxt = IDLE;
            else if (last_word) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Slice shifting, point/column counting, write strobe and status flags
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         feat_r    <= '0;
         pts_r     <= '0;
         pt        <= '0;
         col       <= '0;
         slice     <= '0;
         shreg     <= '0;
         WR_EN     <= 1'b0;
         WR_PT     <= '0;
         WR_COL    <= '0;
         WR_DATA   <= '0;
         LOAD_DONE <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         WR_EN <= 1'b0;
         if (accept) begin
            feat_r    <= feat;
            pts_r     <= data_points;
            pt        <= '0;
            col       <= feat;
            slice     <= '0;
            ERR       <= 1'b0;
            LOAD_DONE <= (data_points == '0);
         end else if (state == SHIFT) begin
            if (ABORT) begin
               ERR   <= 1'b1;
               slice <= '0;
            end else begin
               if (START) ERR <= 1'b1;
               shreg <= word_nxt;
               if (last_slice) begin
                  slice   <= '0;
                  WR_EN   <= 1'b1;
                  WR_DATA <= word_nxt;
                  WR_PT   <= pt;
                  WR_COL  <= col;
                  if (last_col) begin
                     col <= feat_r;
                     pt  <= pt + PTS_W'(1);
                  end else begin
                     col <= col - FEAT_W'(1);
                  end
                  if (last_word) LOAD_DONE <= 1'b1;
               end else begin
                  slice <= slice + SC_W'(1);
               end
            end
         end
      end
   end

endmodule
